display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It supersedes the fixed single-digit combinational decoder.
- Latches a packed hex word through a LOAD/PENDING handshake.
- Commits the word at frame boundaries only, so the display never tears.
- Scans one digit per refresh slot, with a ghost-suppression blanking window.
- Drives SEG/DIG/DP pins directly at the top level.

Parameters:
N_DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
CLK  input  1  system clock; the only clock
RST  input  1  synchronous, active-high reset
DATA  input  4*N_DIGITS  hex code per digit; DATA[4i+3:4i] is digit i
EN  input  N_DIGITS  per-digit enable; 0 = digit blanked
DP_MASK  input  N_DIGITS  per-digit decimal point request; 1 = lit
LOAD  input  1  request to capture DATA/EN/DP_MASK
PENDING  output  1  staged word waiting for frame boundary; LOAD ignored while high
FRAME  output  1  one-cycle pulse on each frame boundary
SEG  output  7  segments, active-low; SEG[6]=a ... SEG[0]=g
DIG  output  N_DIGITS  digit selects, active-low; DIG[i] selects digit i
DP  output  1  decimal point, active-low

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All state changes on the rising CLK edge.
- Reset values:
  - Counters: cnt=0, idx=0.
  - Staging and display registers: 0 (display EN=0, so all blank).
  - Outputs: PENDING=0, FRAME=0, SEG=7'h7F, DIG=all ones, DP=1.
- Slot counter cnt runs 0..REFRESH_DIV-1. At REFRESH_DIV-1: cnt<=0 and idx<=idx+1, wrapping N_DIGITS-1 -> 0.
- Frame boundary: cycle where cnt==REFRESH_DIV-1 and idx==N_DIGITS-1.
- Handshake:
  - LOAD=1 and PENDING=0: capture DATA/EN/DP_MASK into staging; PENDING<=1 next cycle.
  - LOAD while PENDING=1: ignored; staging is unchanged.
  - On a frame boundary with PENDING=1: staging -> display registers and PENDING<=0.
  - Boundary and LOAD in the same cycle with PENDING=0: capture into staging; commit at the following boundary.
  - Boundary with PENDING=1 and LOAD in the same cycle: commit the old staging; the new LOAD is ignored.
- FRAME is high for the one cycle after every boundary, whether or not a commit occurred.
- Output registers: 1-cycle latency from (cnt, idx, display registers) to pins.
  - If cnt < BLANK_CYCLES, or display EN[idx]=0: DIG=all ones, SEG=7'h7F, DP=1.
  - Otherwise: DIG has only bit idx low; SEG=decode(display DATA[idx]); DP=~DP_MASK[idx].
- Decode, active-low, a..g in SEG[6:0]:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Reset mid-operation takes priority over everything. Staged data is discarded. Scan restarts at idx 0, cnt 0, display blank.
- No combinational path from inputs to outputs. At most one DIG bit is low in any cycle.

Test Plan:
(N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 throughout)
1. Hold RST 2 cycles, then release; run 32 cycles with no LOAD -> SEG=7F, DIG=F, DP=1, PENDING=0 throughout; FRAME pulses every 16 cycles.
2. LOAD with DATA=16'h1234, EN=F, DP_MASK=0 -> PENDING=1 until the next FRAME, then 0. In the following frame, per slot: 1 cycle DIG=F, then 3 cycles of DIG/SEG:
   - digit 0: DIG=E, SEG=4C
   - digit 1: DIG=D, SEG=06
   - digit 2: DIG=B, SEG=12
   - digit 3: DIG=7, SEG=4F
   - DP=1 in all slots.
3. LOAD DATA=16'hFEDC, EN=4'b0101, DP_MASK=4'b0001 -> after commit:
   - digit 0: SEG=31, DP=0
   - digit 1: DIG=F, SEG=7F
   - digit 2: SEG=30, DP=1
   - digit 3: DIG=F, SEG=7F
4. LOAD 16'h1111, then LOAD 16'h2222 one cycle later while PENDING=1 -> display shows 1111 (SEG=4F) after commit; 2222 never appears.
5. LOAD asserted exactly on the boundary cycle with PENDING=0 -> old word kept for one full frame; new word appears after the next FRAME.
6. RST for 1 cycle during digit 2 with PENDING=1 -> next cycle SEG=7F, DIG=F, PENDING=0; next non-blank slot is digit 0; display stays blank.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with frame-synchronous
// word commit (LOAD/PENDING handshake) and per-slot ghost-suppression blanking.
module display_scan_controller #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*N_DIGITS-1:0]   DATA,
    input  logic [N_DIGITS-1:0]     EN,
    input  logic [N_DIGITS-1:0]     DP_MASK,
    input  logic                    LOAD,
    output logic                    PENDING,
    output logic                    FRAME,
    output logic [6:0]              SEG,
    output logic [N_DIGITS-1:0]     DIG,
    output logic                    DP
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    // Scan position
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Staging word, waiting for the next frame boundary
    logic [DATA_W-1:0]   stage_data_q, stage_data_d;
    logic [N_DIGITS-1:0] stage_en_q, stage_en_d;
    logic [N_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic                pend_q, pend_d;

    // Word currently shown
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic [N_DIGITS-1:0] disp_en_q, disp_en_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;

    // Pin registers
    logic                frame_q, frame_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] dig_q, dig_d;
    logic                dp_q, dp_d;

    logic                slot_end_c;
    logic                boundary_c;
    logic                blank_win_c;
    logic                lit_c;
    logic [3:0]          cur_nib_c;
    logic                cur_en_c;
    logic                cur_dp_c;

    function automatic logic [6:0] decode_hex(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    assign slot_end_c  = (cnt_q == CNT_LAST);
    assign boundary_c  = slot_end_c && (idx_q == IDX_LAST);
    assign blank_win_c = (32'(cnt_q) < BLANK_CYCLES);

    // Pick the digit fields addressed by the current scan index
    always_comb begin
        cur_nib_c = 4'h0;
        cur_en_c  = 1'b0;
        cur_dp_c  = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_c = disp_data_q[4*i +: 4];
                cur_en_c  = disp_en_q[i];
                cur_dp_c  = disp_dp_q[i];
            end
        end
    end

    assign lit_c = !blank_win_c && cur_en_c;

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        stage_data_d = stage_data_q;
        stage_en_d   = stage_en_q;
        stage_dp_d   = stage_dp_q;
        pend_d       = pend_q;
        disp_data_d  = disp_data_q;
        disp_en_d    = disp_en_q;
        disp_dp_d    = disp_dp_q;
        frame_d      = boundary_c;
        seg_d        = SEG_OFF;
        dig_d        = '1;
        dp_d         = 1'b1;

        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Commit wins over a same-cycle LOAD; LOAD is only taken while idle
        if (boundary_c && pend_q) begin
            disp_data_d = stage_data_q;
            disp_en_d   = stage_en_q;
            disp_dp_d   = stage_dp_q;
            pend_d      = 1'b0;
        end else if (LOAD && !pend_q) begin
            stage_data_d = DATA;
            stage_en_d   = EN;
            stage_dp_d   = DP_MASK;
            pend_d       = 1'b1;
        end

        if (lit_c) begin
            seg_d = decode_hex(cur_nib_c);
            dp_d  = !cur_dp_c;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                dig_d[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_data_q <= '0;
            stage_en_q   <= '0;
            stage_dp_q   <= '0;
            pend_q       <= 1'b0;
            disp_data_q  <= '0;
            disp_en_q    <= '0;
            disp_dp_q    <= '0;
            frame_q      <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= '1;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_data_q <= stage_data_d;
            stage_en_q   <= stage_en_d;
            stage_dp_q   <= stage_dp_d;
            pend_q       <= pend_d;
            disp_data_q  <= disp_data_d;
            disp_en_q    <= disp_en_d;
            disp_dp_q    <= disp_dp_d;
            frame_q      <= frame_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            dp_q         <= dp_d;
        end
    end

    assign PENDING = pend_q;
    assign FRAME   = frame_q;
    assign SEG     = seg_q;
    assign DIG     = dig_q;
    assign DP      = dp_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (4 digits, 4-cycle slots, 1 blank cycle).
module tb_display_scan_controller;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BL = 1;

    logic        clk = 1'b0;
    logic        rst, ld;
    logic [15:0] data;
    logic [3:0]  en, dpm;
    logic        pend, frame, dp;
    logic [6:0]  seg;
    logic [3:0]  dig;

    always #5 clk = ~clk;

    display_scan_controller #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .DATA   (data),
        .EN     (en),
        .DP_MASK(dpm),
        .LOAD   (ld),
        .PENDING(pend),
        .FRAME  (frame),
        .SEG    (seg),
        .DIG    (dig),
        .DP     (dp)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       dp;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [6:0]  dec [16];

    // Reference scan model state
    int          mcnt, midx;
    logic        mpend;
    logic [15:0] s_data, d_data;
    logic [3:0]  s_en, d_en, s_dp, d_dp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: predict pins from the model, advance model, compare after the edge
    task automatic step();
        exp_t       e;
        logic       bnd;
        logic [3:0] nib;
        e   = '0;
        bnd = (mcnt == RD - 1) && (midx == N - 1);
        e.seg = 7'h7F;
        e.dig = 4'hF;
        e.dp  = 1'b1;
        if (!rst) begin
            e.frame = bnd;
            if (mcnt >= BL && d_en[midx]) begin
                nib   = d_data[midx*4 +: 4];
                e.seg = dec[nib];
                e.dig = ~(4'(1) << midx);
                e.dp  = ~d_dp[midx];
            end
        end
        if (rst) begin
            mcnt = 0; midx = 0; mpend = 1'b0;
            s_data = '0; s_en = '0; s_dp = '0;
            d_data = '0; d_en = '0; d_dp = '0;
        end else begin
            if (bnd && mpend) begin
                d_data = s_data; d_en = s_en; d_dp = s_dp;
                mpend  = 1'b0;
            end else if (ld && !mpend) begin
                s_data = data; s_en = en; s_dp = dpm;
                mpend  = 1'b1;
            end
            if (mcnt == RD - 1) begin
                mcnt = 0;
                midx = (midx == N - 1) ? 0 : midx + 1;
            end else begin
                mcnt++;
            end
        end
        e.pend = mpend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dig", 32'(dig), 32'(e.dig));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("pending", 32'(pend), 32'(e.pend));
        chk("frame", 32'(frame), 32'(e.frame));
        chk("dig_onehot", 32'($countones(~dig) <= 1), 32'(1));
    endtask

    // Run one full frame right after a FRAME pulse and tally what each digit shows
    task automatic run_frame(input string tag, input logic [15:0] w,
                             input logic [3:0] e, input logic [3:0] m);
        int   hits [4];
        int   blanks, other;
        logic matched;
        blanks = 0;
        other  = 0;
        for (int i = 0; i < 4; i++) hits[i] = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (dig == 4'hF) begin
                blanks++;
            end else begin
                matched = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (dig == ~(4'(1) << i) && seg == dec[w[4*i +: 4]] && dp == ~m[i]) begin
                        hits[i]++;
                        matched = 1'b1;
                    end
                end
                if (!matched) other++;
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_digit%0d_cycles", tag, i), 32'(hits[i]), e[i] ? 32'(3) : 32'(0));
        chk({tag, "_blank_cycles"}, 32'(blanks), 32'(16 - 3 * $countones(e)));
        chk({tag, "_unexpected_cycles"}, 32'(other), 32'(0));
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (frame !== 1'b1 && k < 40);
        chk({tag, "_frame_seen"}, 32'(frame), 32'(1));
    endtask

    task automatic load_word(input logic [15:0] w, input logic [3:0] e, input logic [3:0] m);
        ld = 1'b1; data = w; en = e; dpm = m;
        step();
        ld = 1'b0;
    endtask

    initial begin
        int frames;
        int k;
        dec = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        mcnt = 0; midx = 0; mpend = 1'b0;
        s_data = '0; s_en = '0; s_dp = '0;
        d_data = '0; d_en = '0; d_dp = '0;
        rst = 1'b1; ld = 1'b0; data = '0; en = '0; dpm = '0;

        // 1: reset, then idle scanning
        step();
        step();
        rst = 1'b0;
        frames = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (frame === 1'b1) frames++;
        end
        chk("t1_frames_in_32", 32'(frames), 32'(2));

        // 2: plain word, all digits on
        load_word(16'h1234, 4'hF, 4'h0);
        chk("t2_pending_set", 32'(pend), 32'(1));
        wait_frame("t2");
        chk("t2_pending_clr", 32'(pend), 32'(0));
        run_frame("t2", 16'h1234, 4'hF, 4'h0);

        // 3: disabled digits and decimal point
        load_word(16'hFEDC, 4'b0101, 4'b0001);
        wait_frame("t3");
        run_frame("t3", 16'hFEDC, 4'b0101, 4'b0001);

        // 4: second LOAD while pending is dropped
        ld = 1'b1; data = 16'h1111; en = 4'hF; dpm = 4'h0;
        step();
        data = 16'h2222;
        step();
        ld = 1'b0;
        chk("t4_pending_held", 32'(pend), 32'(1));
        wait_frame("t4");
        run_frame("t4", 16'h1111, 4'hF, 4'h0);

        // 5: LOAD on the boundary cycle commits one frame later
        k = 0;
        while (!(mcnt == RD - 1 && midx == N - 1) && k < 40) begin
            step();
            k++;
        end
        load_word(16'h8888, 4'hF, 4'h0);
        chk("t5_frame_on_load", 32'(frame), 32'(1));
        chk("t5_pending_set", 32'(pend), 32'(1));
        run_frame("t5_old", 16'h1111, 4'hF, 4'h0);
        run_frame("t5_new", 16'h8888, 4'hF, 4'h0);

        // 6: reset mid-frame with a staged word
        load_word(16'h9999, 4'hF, 4'h0);
        k = 0;
        while (midx != 2 && k < 40) begin
            step();
            k++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_seg_after_rst", 32'(seg), 32'(7'h7F));
        chk("t6_dig_after_rst", 32'(dig), 32'(4'hF));
        chk("t6_pending_after_rst", 32'(pend), 32'(0));
        run_frame("t6_blank", 16'h0000, 4'h0, 4'h0);
        load_word(16'h0123, 4'hF, 4'h0);
        wait_frame("t6");
        run_frame("t6_after", 16'h0123, 4'hF, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
